// File: rtl/rr_arbiter_2to1_pkg.sv
// ============================================================================
// Module   : rr_arbiter_2to1_pkg
// Brief    : Shared channel-index constants and default width for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_arbiter_2to1_pkg;

   localparam int   DW_DEFAULT = 8;
   localparam logic CH0        = 1'b0;
   localparam logic CH1        = 1'b1;

endpackage : rr_arbiter_2to1_pkg

`default_nettype wire

// File: rtl/rr_grant_2.sv
// ============================================================================
// Module   : rr_grant_2
// Brief    : Combinational two-way round-robin grant with a sticky select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_grant_2
   import rr_arbiter_2to1_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic sel_o
);

   logic w_gnt0;
   logic w_gnt1;

   // On a tie the channel that did not win last time takes the grant.
   assign w_gnt0 = req0_i & (~req1_i | (last_grant_i == CH1));
   assign w_gnt1 = req1_i & (~req0_i | (last_grant_i == CH0));

   assign gnt0_o = w_gnt0;
   assign gnt1_o = w_gnt1;
   assign sel_o  = w_gnt1 ? CH1 : (w_gnt0 ? CH0 : last_grant_i);

endmodule : rr_grant_2

`default_nettype wire

// File: rtl/rr_arbiter_2to1.sv
// ============================================================================
// Module   : rr_arbiter_2to1
// Brief    : Two-channel round-robin arbiter feeding a one-entry output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_2to1
   import rr_arbiter_2to1_pkg::*;
#(
   parameter int DW             = DW_DEFAULT,
   parameter bit PRIO0_AT_RESET = 1'b1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in0_valid,
   input  logic [DW-1:0] in0_data,
   output logic          in0_ready,
   input  logic          in1_valid,
   input  logic [DW-1:0] in1_data,
   output logic          in1_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_src,
   input  logic          out_ready,
   output logic          sel
);

   // Reset as if the non-preferred channel had just won, so the preferred one takes the first tie.
   localparam logic c_LAST_GRANT_RST = PRIO0_AT_RESET ? CH1 : CH0;

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q,  out_data_d;
   logic          out_src_q,   out_src_d;
   logic          last_grant_q, last_grant_d;

   logic w_gnt0;
   logic w_gnt1;
   logic w_sel;
   logic w_acc_en;
   logic w_accept;

   rr_grant_2 u_grant (
      .req0_i       (in0_valid),
      .req1_i       (in1_valid),
      .last_grant_i (last_grant_q),
      .gnt0_o       (w_gnt0),
      .gnt1_o       (w_gnt1),
      .sel_o        (w_sel)
   );

   assign w_acc_en  = ~out_valid_q | out_ready;
   assign in0_ready = ~rst & w_acc_en & w_gnt0;
   assign in1_ready = ~rst & w_acc_en & w_gnt1;
   assign w_accept  = in0_ready | in1_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (w_accept) begin
         out_valid_d  = 1'b1;
         out_data_d   = (w_sel == CH1) ? in1_data : in0_data;
         out_src_d    = w_sel;
         last_grant_d = w_sel;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= CH0;
         last_grant_q <= c_LAST_GRANT_RST;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign sel       = w_sel;

endmodule : rr_arbiter_2to1

`default_nettype wire

// File: tb/tb_rr_arbiter_2to1.sv
// ============================================================================
// Module   : tb_rr_arbiter_2to1
// Brief    : Directed bench with a reference model and expected-beat queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter_2to1;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in0_valid, in1_valid;
   logic [DW-1:0] in0_data,  in1_data;
   logic          in0_ready, in1_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_src;
   logic          out_ready;
   logic          sel;

   int n_cmp  = 0;
   int n_fail = 0;

   logic        m_valid = 1'b0;
   logic        m_last  = 1'b1;
   logic [DW:0] sb[$];
   logic [DW-1:0] seen_data[$];
   logic          seen_src[$];
   logic        obs_r0, obs_r1;

   rr_arbiter_2to1 #(.DW(DW), .PRIO0_AT_RESET(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: check at negedge against the model, then advance the model past the posedge.
   task automatic step();
      logic acc, g0, g1, any, nv, nl;
      @(negedge clk);
      acc = !m_valid || out_ready;
      g0  = in0_valid && (!in1_valid || m_last);
      g1  = in1_valid && (!in0_valid || !m_last);
      any = g0 || g1;
      obs_r0 = in0_ready;
      obs_r1 = in1_ready;
      chk("in0_ready", {31'd0, in0_ready}, {31'd0, !rst && acc && g0});
      chk("in1_ready", {31'd0, in1_ready}, {31'd0, !rst && acc && g1});
      if (any) chk("sel", {31'd0, sel}, {31'd0, g1});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, sb[0][DW-1:0]});
            chk("out_src",  {31'd0, out_src},  {31'd0, sb[0][DW]});
            if (out_ready) begin
               if (!rst) begin
                  seen_data.push_back(out_data);
                  seen_src.push_back(out_src);
               end
               void'(sb.pop_front());
            end
         end
      end
      nv = m_valid;
      nl = m_last;
      if (rst) begin
         nv = 1'b0;
         nl = 1'b1;
         sb.delete();
      end else if (acc && any) begin
         sb.push_back({g1, g1 ? in1_data : in0_data});
         nv = 1'b1;
         nl = g1;
      end else if (out_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      m_valid = nv;
      m_last  = nl;
      #1;
   endtask

   initial begin
      int i0, i1;
      logic [DW-1:0] rr_exp [6];
      rr_exp = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};

      // Reset with both channels requesting.
      rst = 1'b1; out_ready = 1'b1;
      in0_valid = 1'b1; in0_data = 8'h01;
      in1_valid = 1'b1; in1_data = 8'h02;
      step(); step();
      rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_src",  {31'd0, out_src},  32'd0);
      step();

      // Single channel beats, one from each side.
      in0_valid = 1'b1; in0_data = 8'hA5;
      step();
      chk("single_r0", {31'd0, obs_r0}, 32'd1);
      in0_valid = 1'b0;
      chk("single_data", {24'd0, out_data}, 32'hA5);
      chk("single_src",  {31'd0, out_src},  32'd0);
      step();
      in1_valid = 1'b1; in1_data = 8'hB6;
      step();
      in1_valid = 1'b0;
      step();

      // Round-robin with both channels busy.
      seen_data.delete(); seen_src.delete();
      i0 = 0; i1 = 0;
      for (int k = 0; k < 20 && (i0 < 3 || i1 < 3); k++) begin
         in0_valid = (i0 < 3); in0_data = 8'h10 + 8'(i0);
         in1_valid = (i1 < 3); in1_data = 8'h20 + 8'(i1);
         step();
         if (obs_r0) i0++;
         if (obs_r1) i1++;
      end
      chk("rr_all_accepted", {31'd0, (i0 == 3) && (i1 == 3)}, 32'd1);
      in0_valid = 1'b0; in1_valid = 1'b0;
      step();
      chk("rr_count", seen_data.size(), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < seen_data.size()) begin
            chk($sformatf("rr_order%0d", k), {24'd0, seen_data[k]}, {24'd0, rr_exp[k]});
            chk($sformatf("rr_src%0d", k),   {31'd0, seen_src[k]},  {31'd0, 1'(k % 2)});
         end
      end

      // Backpressure: register holds 33 while the consumer stalls.
      in0_valid = 1'b1; in0_data = 8'h33;
      step();
      in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 8'h34; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_r1", {31'd0, obs_r1}, 32'd0);
         chk("stall_data", {24'd0, out_data}, 32'h33);
      end
      out_ready = 1'b1;
      step();
      chk("release_r1", {31'd0, obs_r1}, 32'd1);
      in1_valid = 1'b0;
      chk("release_data", {24'd0, out_data}, 32'h34);
      step(); step();

      // Drain to empty keeps the last payload.
      in0_valid = 1'b1; in0_data = 8'h44;
      step();
      in0_valid = 1'b0;
      chk("drain_valid1", {31'd0, out_valid}, 32'd1);
      step();
      chk("drain_valid0", {31'd0, out_valid}, 32'd0);
      chk("drain_data",   {24'd0, out_data},  32'h44);
      step();

      // Reset while a beat is held.
      in0_valid = 1'b1; in0_data = 8'h55;
      step();
      in0_valid = 1'b0; out_ready = 1'b0;
      step();
      chk("pre_rst_data", {24'd0, out_data}, 32'h55);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      in0_valid = 1'b1; in0_data = 8'h66;
      in1_valid = 1'b1; in1_data = 8'h77;
      step();
      chk("post_rst_tie_r0", {31'd0, obs_r0}, 32'd1);
      chk("post_rst_tie_r1", {31'd0, obs_r1}, 32'd0);
      in0_valid = 1'b0;
      step();
      in1_valid = 1'b0;
      step(); step();
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_rr_arbiter_2to1

`default_nettype wire

// File: doc/rr_arbiter_2to1.md
Name: rr_arbiter_2to1

Overview:
- Two-channel round-robin arbiter with valid/ready handshakes; sits directly upstream of the 2-to-1 data multiplexer.
- Each cycle it picks one requesting input channel and drives the select line for the downstream 2:1 select path.
- It captures the winning beat into a one-entry output register and presents it with valid/ready to the consumer.
- Fairness: the channel that won most recently loses the next tie.

Parameters:
- DW, 8, data width of each input channel and of the output.
- PRIO0_AT_RESET, 1, 1 means ch0 wins the first tie after reset; 0 means ch1 wins it.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  channel 0 holds a beat.
- in0_data  input  DW  channel 0 payload.
- in0_ready  output  1  channel 0 beat accepted this cycle.
- in1_valid  input  1  channel 1 holds a beat.
- in1_data  input  DW  channel 1 payload.
- in1_ready  output  1  channel 1 beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DW  registered payload.
- out_src  output  1  source of out_data (0 means ch0, 1 means ch1).
- out_ready  input  1  consumer takes the beat this cycle.
- sel  output  1  combinational grant select this cycle; feeds the 2:1 data mux select.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0.
  - last_grant = ~PRIO0_AT_RESET, so the preferred channel wins the first tie.
  - While rst=1, in0_ready=0 and in1_ready=0.
- Reset mid-operation: a beat in the output register is dropped; no ready is asserted during reset.
- Accept enable: acc_en = ~out_valid | out_ready. The register is free, or it is drained in the same cycle.
- Grant (combinational):
  - Only in0_valid is high: grant ch0.
  - Only in1_valid is high: grant ch1.
  - Both are high: grant ~last_grant.
  - Neither is high: no grant; sel holds its last granted value.
- Readies:
  - in0_ready = acc_en & grant0.
  - in1_ready = acc_en & grant1.
  - At most one ready is high in any cycle.
  - Ready never depends on the in*_ready outputs, so there are no combinational loops. in*_ready does depend on out_ready.
- On accept (any in*_ready high):
  - out_data <= granted in*_data.
  - out_src <= granted index.
  - out_valid <= 1.
  - last_grant <= granted index.
- Drain with no accept (out_valid & out_ready and no new grant): out_valid <= 0. out_data and out_src hold their values.
- Stall (out_valid & ~out_ready): the output register holds, both readies are 0, and last_grant holds.
- Timing:
  - Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
  - Sustained throughput is 1 beat per cycle when out_ready is held high.
- States (implicit in out_valid):
  - EMPTY goes to FULL on accept.
  - FULL stays FULL on accept+drain or on stall.
  - FULL goes to EMPTY on drain without accept.
- Inputs are assumed AXI-style: a valid input does not drop its valid or change its data until its ready is seen. The block does not check this.
- Width rules: no arithmetic. All data paths are exactly DW bits.

Decomposition:
- Shared package holds:
  - CH0=1'b0 and CH1=1'b1 index constants.
  - The default DW.
- One sub-module, rr_grant_2: a purely combinational grant from (req0, req1, last_grant) to (gnt0, gnt1, sel).
- last_grant stays in the parent so all state lives in one always block.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both valids high → out_valid=0, out_data=0, out_src=0, in0_ready=in1_ready=0.
- Single channel: in0_valid=1 with data 8'hA5, out_ready=1 → in0_ready=1 that cycle; next cycle out_valid=1, out_data=A5, out_src=0.
- Round-robin:
  - Stimulus: both valids held high; ch0 supplies 8'h10, 11, 12 in turn and ch1 supplies 8'h20, 21, 22; out_ready=1.
  - Required output order: 10, 20, 11, 21, 12, 22, with out_src toggling 0,1,0,1,…
- Backpressure:
  - Fill the register with 8'h33, then hold out_ready=0 for 3 cycles → both readies=0 and out_data stays 33.
  - Release out_ready → the next beat is accepted that same cycle (throughput is kept).
- Drain to empty: one beat 8'h44 with out_ready=1, then no valids → out_valid goes 1 then 0; out_data stays 44.
- Reset mid-operation: out_valid=1 holding 8'h55, assert rst for 1 cycle → out_valid=0; the first tie after reset goes to ch0 (PRIO0_AT_RESET=1).
